// File: rtl/la32_pkg.sv
// Shared LoongArch32 pipeline definitions: branch opcodes, reset vector and
// the field layout of the fetch-to-decode bundle.
package la32_pkg;

   typedef enum logic [5:0] {
      OP_JIRL = 6'h13,
      OP_B    = 6'h14,
      OP_BL   = 6'h15,
      OP_BEQ  = 6'h16,
      OP_BNE  = 6'h17
   } opcode_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

   localparam int unsigned ZIP_PC   = 0;
   localparam int unsigned ZIP_INST = 32;
   localparam int unsigned ZIP_PRED = 64;
   localparam int unsigned ZIP_W    = 65;

   function automatic logic [ZIP_W-1:0] pack_zip(input logic        pred,
                                                 input logic [31:0] inst,
                                                 input logic [31:0] pc);
      logic [ZIP_W-1:0] z;
      z                 = '0;
      z[ZIP_PRED]       = pred;
      z[ZIP_INST +: 32] = inst;
      z[ZIP_PC +: 32]   = pc;
      return z;
   endfunction

endpackage

// File: rtl/static_bpred.sv
// Static direct-branch predictor: b/bl always taken, beq/bne taken when the
// offset is backward. target is the predicted next fetch address.
module static_bpred
   import la32_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic        taken,
   output logic [31:0] target
);

   logic [31:0] off_long;
   logic [31:0] off_cond;

   assign off_long = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
   assign off_cond = {{14{inst[25]}}, inst[25:10], 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = pc + 32'd4;
      case (inst[31:26])
         OP_B, OP_BL: begin
            taken  = 1'b1;
            target = pc + off_long;
         end
         OP_BEQ, OP_BNE: begin
            // Sign bit of the offset doubles as the backward-taken hint.
            if (inst[25]) begin
               taken  = 1'b1;
               target = pc + off_cond;
            end
         end
         OP_JIRL: taken = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, 1-cycle SRAM request, static prediction,
// one-entry skid buffer and registered hand-off to decode.
module if_stage
   import la32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic             clk,
   input  logic             rst,
   output logic             inst_sram_en,
   output logic [31:0]      inst_sram_addr,
   input  logic [31:0]      inst_sram_rdata,
   input  logic             id_allowin,
   input  logic             flush,
   input  logic [31:0]      pc_real,
   output logic             if_to_id_valid,
   output logic [ZIP_W-1:0] if_to_id_zip
);

   logic             req_out;
   logic [31:0]      req_pc;
   logic             buf_valid;
   logic [31:0]      buf_inst;
   logic [31:0]      buf_pc;
   logic             out_valid;
   logic [ZIP_W-1:0] out_zip;

   logic             advance;
   logic             resp_taken;
   logic [31:0]      resp_next;
   logic             buf_taken;
   logic [31:0]      buf_next;

   static_bpred u_resp_bp (
      .inst   (inst_sram_rdata),
      .pc     (req_pc),
      .taken  (resp_taken),
      .target (resp_next)
   );

   static_bpred u_buf_bp (
      .inst   (buf_inst),
      .pc     (buf_pc),
      .taken  (buf_taken),
      .target (buf_next)
   );

   assign advance = ~out_valid | id_allowin;

   // The response path is combinational into the address so taken branches
   // redirect without a bubble.
   always_comb begin
      inst_sram_en   = ~rst & (flush | (~req_out & ~buf_valid) |
                               ((req_out | buf_valid) & advance));
      inst_sram_addr = '0;
      if (!rst) begin
         if (flush)                    inst_sram_addr = pc_real;
         else if (req_out && advance)  inst_sram_addr = resp_next;
         else if (buf_valid && advance) inst_sram_addr = buf_next;
         else                          inst_sram_addr = RESET_PC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_out   <= 1'b0;
         req_pc    <= '0;
         buf_valid <= 1'b0;
         buf_inst  <= '0;
         buf_pc    <= '0;
         out_valid <= 1'b0;
         out_zip   <= '0;
      end else begin
         req_out <= inst_sram_en;
         if (inst_sram_en) req_pc <= inst_sram_addr;

         if (flush) begin
            buf_valid <= 1'b0;
            out_valid <= 1'b0;
         end else if (req_out && advance) begin
            out_valid <= 1'b1;
            out_zip   <= pack_zip(resp_taken, inst_sram_rdata, req_pc);
         end else if (req_out) begin
            buf_valid <= 1'b1;
            buf_inst  <= inst_sram_rdata;
            buf_pc    <= req_pc;
         end else if (buf_valid && advance) begin
            out_valid <= 1'b1;
            out_zip   <= pack_zip(buf_taken, buf_inst, buf_pc);
            buf_valid <= 1'b0;
         end else if (id_allowin) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign if_to_id_valid = out_valid;
   assign if_to_id_zip   = out_zip;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed timing checks plus a random
// run scored against a program-order fetch model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata = '0;
   logic        id_allowin;
   logic        flush;
   logic [31:0] pc_real;
   logic        if_to_id_valid;
   logic [64:0] if_to_id_zip;

   int vectors     = 0;
   int miscompares = 0;
   int acc_cnt     = 0;

   logic [31:0] prog [256];
   localparam logic [31:0] NOP  = 32'h0280_0000;
   localparam logic [31:0] BASE = 32'h1c00_0000;

   if_stage #(.RESET_PC(32'h1c00_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .id_allowin      (id_allowin),
      .flush           (flush),
      .pc_real         (pc_real),
      .if_to_id_valid  (if_to_id_valid),
      .if_to_id_zip    (if_to_id_zip)
   );

   always #5 clk = ~clk;

   // Instruction SRAM: one-cycle read latency, aliased over 256 words.
   always @(posedge clk)
      if (inst_sram_en) inst_sram_rdata <= prog[inst_sram_addr[9:2]];

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: program-order fetch with backward-taken / forward-not-taken.
   function automatic logic [64:0] ref_entry(input logic [31:0] pc, output logic [31:0] nxt);
      logic [31:0]        inst;
      logic [5:0]         op;
      logic signed [25:0] o26;
      logic signed [15:0] o16;
      logic               taken;
      int                 off;
      inst  = prog[pc[9:2]];
      op    = inst[31:26];
      taken = 1'b0;
      off   = 0;
      if (op == 6'h14 || op == 6'h15) begin
         o26   = {inst[9:0], inst[25:10]};
         off   = int'(o26) * 4;
         taken = 1'b1;
      end else if (op == 6'h16 || op == 6'h17) begin
         o16 = inst[25:10];
         if (o16 < 0) begin
            off   = int'(o16) * 4;
            taken = 1'b1;
         end
      end
      nxt = taken ? pc + 32'(off) : pc + 32'd4;
      return {taken, inst, pc};
   endfunction

   // Scoreboard monitor: expected stream is regenerated from the model PC.
   logic [64:0] exp_q [$];
   logic [31:0] mpc = BASE;
   logic        drop_next = 1'b0;

   always @(negedge clk) begin
      logic [31:0] nxt;
      logic [64:0] e;
      if (rst) begin
         exp_q.delete();
         mpc       = BASE;
         drop_next = 1'b0;
      end else begin
         if (drop_next) chk("flush_drop_valid", 65'(if_to_id_valid), 65'd0);
         if (flush) begin
            exp_q.delete();
            mpc       = pc_real;
            drop_next = 1'b1;
         end else begin
            drop_next = 1'b0;
            if (if_to_id_valid && id_allowin) begin
               if (exp_q.size() == 0) begin
                  exp_q.push_back(ref_entry(mpc, nxt));
                  mpc = nxt;
               end
               e = exp_q.pop_front();
               chk("stream_zip", if_to_id_zip, e);
               acc_cnt++;
            end
         end
      end
   end

   task automatic tick(input logic r, input logic a, input logic f, input logic [31:0] pr);
      @(posedge clk);
      #1;
      rst        = r;
      id_allowin = a;
      flush      = f;
      pc_real    = pr;
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_inst();
      int          k;
      int          s;
      logic [25:0] o26;
      logic [15:0] o16;
      k = int'($urandom_range(0, 9));
      s = int'($urandom_range(0, 16)) - 8;
      case (k)
         0, 1: begin
            o26 = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'(s);
            return {(k == 0) ? 6'h14 : 6'h15, o26[15:0], o26[25:16]};
         end
         2, 3: begin
            o16 = 16'(s);
            return {(k == 2) ? 6'h16 : 6'h17, o16, 10'($urandom)};
         end
         4:       return {6'h13, 26'($urandom)};
         default: return {6'($urandom_range(0, 18)), 26'($urandom)};
      endcase
   endfunction

   initial begin
      rst = 1'b1; id_allowin = 1'b1; flush = 1'b0; pc_real = '0;
      for (int i = 0; i < 256; i++) prog[i] = NOP;

      // Straight line then backward beq at 1c000010 (offset -4 words).
      prog[4] = {6'h16, 16'hfffc, 10'h0};
      tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      chk("reset_en", 65'(inst_sram_en), 65'd0);
      chk("reset_addr", 65'(inst_sram_addr), 65'd0);
      chk("reset_valid", 65'(if_to_id_valid), 65'd0);
      chk("reset_zip", if_to_id_zip, 65'd0);
      for (int n = 0; n < 7; n++) begin
         tick(0, 1, 0, 0);
         if (n < 5) chk("seq_addr", 65'(inst_sram_addr), 65'(BASE + 32'(4 * n)));
         if (n < 2) chk("seq_valid_lat", 65'(if_to_id_valid), 65'd0);
         if (n == 2) chk("first_out", {if_to_id_valid, if_to_id_zip}, {1'b1, 1'b0, NOP, BASE});
         if (n == 5) chk("beq_back_redirect", {inst_sram_en, inst_sram_addr}, {1'b1, BASE});
         if (n == 6) chk("beq_back_pred", 65'({if_to_id_valid, if_to_id_zip[64], if_to_id_zip[31:0]}),
                         65'({1'b1, 1'b1, BASE + 32'h10}));
      end

      // Forward beq (not taken), stall, flush, flush-in-stall, reset-in-stall.
      tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      prog[4] = {6'h16, 16'h0004, 10'h0};
      for (int n = 0; n < 29; n++) begin
         logic a, f, r;
         logic [31:0] pr;
         a = !(n inside {[9:11], [17:21], 24, 25, 26, 27});
         f = (n == 14) || (n inside {[19:21]});
         pr = (n == 14) ? BASE + 32'h100 : BASE + 32'h200;
         r = (n == 26) || (n == 27);
         tick(r, a, f, f ? pr : 32'h0);
         if (n == 5) chk("beq_fwd_next", 65'(inst_sram_addr), 65'(BASE + 32'h14));
         if (n == 6) chk("beq_fwd_pred", 65'({if_to_id_valid, if_to_id_zip[64], if_to_id_zip[31:0]}),
                         65'({1'b1, 1'b0, BASE + 32'h10}));
         if (n == 8) chk("req_20", {inst_sram_en, inst_sram_addr}, {1'b1, BASE + 32'h20});
         if (n inside {[9:11]}) chk("stall_no_req", 65'(inst_sram_en), 65'd0);
         if (n == 12) chk("stall_resume", {inst_sram_en, inst_sram_addr}, {1'b1, BASE + 32'h24});
         if (n == 13) chk("stall_drain", 65'({if_to_id_valid, if_to_id_zip[31:0]}), 65'({1'b1, BASE + 32'h20}));
         if (n == 14) chk("flush_req", {inst_sram_en, inst_sram_addr}, {1'b1, BASE + 32'h100});
         if (n == 15) chk("flush_next", {if_to_id_valid, inst_sram_addr}, {1'b0, BASE + 32'h104});
         if (n == 16) chk("flush_target_out", 65'({if_to_id_valid, if_to_id_zip[31:0]}), 65'({1'b1, BASE + 32'h100}));
         if (n inside {[19:21]}) chk("flush_hold_req", {inst_sram_en, inst_sram_addr}, {1'b1, BASE + 32'h200});
         if (n == 22) chk("flush_hold_after", {if_to_id_valid, inst_sram_en, inst_sram_addr},
                          {1'b0, 1'b1, BASE + 32'h204});
         if (n == 23) chk("flush_hold_out", 65'({if_to_id_valid, if_to_id_zip[31:0]}), 65'({1'b1, BASE + 32'h200}));
         if (n == 26) chk("rst_comb_out", {inst_sram_en, inst_sram_addr}, 65'd0);
         if (n == 27) chk("rst_state", {if_to_id_valid, if_to_id_zip}, 66'd0);
         if (n == 28) chk("rst_first_req", {inst_sram_en, inst_sram_addr}, {1'b1, BASE});
      end

      // Random program and random handshake/flush/reset traffic.
      for (int i = 0; i < 256; i++) prog[i] = rand_inst();
      tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      acc_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         logic f;
         f = ($urandom_range(0, 19) == 0);
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, f,
              f ? BASE + {$urandom_range(0, 255), 2'b00} : 32'h0);
         if (inst_sram_en) chk("addr_aligned", 65'(inst_sram_addr[1:0]), 65'd0);
      end
      chk("progress", 65'(acc_cnt > 200), 65'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage in-order LoongArch32 pipeline. It owns the fetch PC, issues one request per cycle to the 1-cycle-latency instruction SRAM, and predicts direct branches statically (backward-taken/forward-not-taken). It redirects on the decode-stage flush and delivers `{predict, inst, pc}` to decode through a valid/allowin handshake. A one-entry skid buffer absorbs the SRAM response whenever decode stalls.

## Interface
- `RESET_PC`, 32'h1c00_0000: first fetch address after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_sram_en`  out  1  request strobe; read data returns next cycle, SRAM always ready.
- `inst_sram_addr`  out  32  request byte address, word aligned.
- `inst_sram_rdata`  in  32  data for the request issued in the previous cycle.
- `id_allowin`  in  1  decode accepts `if_to_id_*` this cycle.
- `flush`  in  1  decode redirect; level, honoured every cycle it is high.
- `pc_real`  in  32  correct next PC, valid when `flush`=1.
- `if_to_id_valid`  out  1  output register holds a live instruction.
- `if_to_id_zip`  out  65  `{predict[64], inst[63:32], pc[31:0]}`, registered.

## Operation
- State:
  - `req_out`: response due next cycle.
  - `req_pc`: address of the outstanding request.
  - `buf_valid`/`buf_inst`/`buf_pc`: skid buffer.
  - `out_valid`/`out_zip`: output register.
- `advance = ~out_valid | id_allowin`.
- Prediction `bp(inst,pc)` → `{taken, target}`:
  - opcode[31:26] 0x14 (b) or 0x15 (bl): taken; target = pc + sext({inst[9:0],inst[25:10],2'b0}).
  - 0x16 (beq) or 0x17 (bne): taken iff inst[25]=1; target = pc + sext({inst[25:10],2'b0}).
  - Everything else, including jirl: not taken.
  - `next = taken ? target : pc+4`; 32-bit wrap, no overflow detection.
- Response handling when `req_out` and `~flush`:
  - If `advance`: `out_valid<=1`, `out_zip<={taken, rdata, req_pc}`.
  - Else: `buf_valid<=1`, `buf_inst<=rdata`, `buf_pc<=req_pc`.
- Buffer drain when `buf_valid & advance & ~flush`: output register loads `{bp(buf).taken, buf_inst, buf_pc}`; `buf_valid<=0`.
- If nothing loads and `id_allowin`: `out_valid<=0`.
- Issue:
  - `inst_sram_en = ~rst & (flush | (~req_out & ~buf_valid) | ((req_out | buf_valid) & advance))`.
  - `req_out <= inst_sram_en`.
  - `req_pc <= inst_sram_addr` whenever en=1.
- Address priority:
  1. `flush`: `pc_real`.
  2. Response consumed: `next` of response.
  3. Buffer drained: `next` of buffer.
  4. Otherwise `RESET_PC`; reachable only in the first cycle after reset.
- Flush has priority over everything:
  - The response arriving that cycle is discarded.
  - `buf_valid<=0`, `out_valid<=0`.
  - A new request to `pc_real` is issued in the same cycle.
- Reset values:
  - `inst_sram_en=0`, `inst_sram_addr=0`.
  - `if_to_id_valid=0`, `if_to_id_zip=0`.
  - `req_out=0`, `buf_valid=0`.

## Timing
- Request in cycle t; data at t+1; in output register at t+2 (decode sees it at t+2).
- Sustained throughput is 1 inst/cycle, including predicted-taken branches (zero-bubble redirect, combinational path rdata→bp→addr).
- `id_allowin` low for N cycles: exactly one response is buffered. No request is issued while stalled. The first cycle with `id_allowin` high drains the buffer and issues the next request.
- Flush at t:
  - Wrong-path output is dropped at t+1.
  - The `pc_real` instruction is valid at output in cycle t+2.
- Flush held several cycles while decode stalls: each cycle re-issues `pc_real` and discards the previous response. The stream resumes the cycle after flush falls.
- Reset mid-operation: all state is cleared at the clock edge; the first request to `RESET_PC` is issued the cycle after `rst` falls.
- Simultaneous flush and `id_allowin`: flush wins; the output goes invalid.

## Structure
- Shared package `la32_pkg`: opcode constants (OP_B, OP_BL, OP_BEQ, OP_BNE, OP_JIRL), `RESET_PC` default, zip field offsets (ZIP_PC, ZIP_INST, ZIP_PRED, ZIP_W=65).
- One sub-module `static_bpred` (combinational: inst, pc → taken, target). It is instantiated twice, once for the response path and once for the buffer path.
- `if_stage` holds the PC/request, skid buffer and output registers.

## Test plan
- Reset release, `id_allowin`=1, straight-line code: `inst_sram_addr` 1c000000, 1c000004, 1c000008 on consecutive cycles; first output valid 2 cycles after first request, predict=0.
- `beq` at 1c000010 with offset −4 words: `predict`=1, next request 1c000000 in the cycle the beq response arrives, no bubble. Same beq with positive offset: predict=0, next request 1c000014.
- `id_allowin`=0 for 3 cycles after request to 1c000020: no further requests; the 1c000020 instruction is held in the buffer and presented once `id_allowin`=1; requests resume at 1c000024.
- `flush`=1 with `pc_real`=1c000100 while a response is in flight: the response is discarded, output invalid next cycle, request 1c000100 issued the same cycle, its instruction valid two cycles later.
- `flush` held 3 cycles during an `id_allowin`=0 stall: the buffer is cleared, no stale instruction ever shows `if_to_id_valid`=1, and the stream restarts at `pc_real`.
- `rst` asserted mid-stream with buffer full: next cycle all outputs are 0; after release the first request is 1c000000.
